// File: rtl/usb_devrx.sv
// usb_devrx: full-speed USB receive packet stage.
// Detects SYNC, NRZI-decodes, strips stuff bits, assembles bytes and
// checks PID / CRC5 / CRC16, reporting error flags with end-of-packet.
module usb_devrx #(
   parameter int unsigned SYNC_MIN_ZEROS = 5,
   parameter int unsigned IDLE_J         = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_strb,
   input  logic       rx_dp,
   input  logic       rx_dn,
   output logic       rx_active,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eop,
   output logic [3:0] rx_err
);

   localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
   localparam int JW = $clog2(IDLE_J + 1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_WAIT_EOP,
      S_EOP
   } state_t;

   state_t          state_q, state_d;
   logic [JW-1:0]   jcnt_q, jcnt_d;
   logic [ZW-1:0]   zcnt_q, zcnt_d;
   logic            prev_q, prev_d;
   logic [2:0]      ones_q, ones_d;
   logic [6:0]      shreg_q, shreg_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [2:0]      nbytes_q, nbytes_d;
   logic [7:0]      pid_q, pid_d;
   logic [4:0]      crc5_q, crc5_d;
   logic [15:0]     crc16_q, crc16_d;
   logic            stuff_err_q, stuff_err_d;
   logic            active_q, active_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            eop_q, eop_d;
   logic [3:0]      err_q, err_d;

   logic            is_j, is_k, is_se0, is_se1;
   logic            dbit;
   logic [7:0]      new_byte;
   logic            crc5_fb, crc16_fb;
   logic            pid_err, crc_err, align_err;
   logic [3:0]      err_now;

   assign is_j     = rx_dp & ~rx_dn;
   assign is_k     = ~rx_dp & rx_dn;
   assign is_se0   = ~rx_dp & ~rx_dn;
   assign is_se1   = rx_dp & rx_dn;
   // NRZI: unchanged level decodes as 1
   assign dbit     = (rx_dp == prev_q);
   assign new_byte = {dbit, shreg_q};
   assign crc5_fb  = dbit ^ crc5_q[4];
   assign crc16_fb = dbit ^ crc16_q[15];

   // End-of-packet error summary from the accumulated packet state
   always_comb begin
      pid_err   = (pid_q[7:4] != ~pid_q[3:0]);
      align_err = (bitcnt_q != 3'd0) || (nbytes_q == 3'd0);
      case (pid_q[1:0])
         2'b01:   crc_err = (nbytes_q != 3'd3) || (crc5_q != 5'b01100);
         2'b11:   crc_err = (nbytes_q < 3'd3) || (crc16_q != 16'h800D);
         default: crc_err = (nbytes_q != 3'd1);
      endcase
      err_now = {stuff_err_q, align_err, crc_err, pid_err};
   end

   // Next-state and output logic; nothing advances without rx_strb
   always_comb begin
      state_d     = state_q;
      jcnt_d      = jcnt_q;
      zcnt_d      = zcnt_q;
      prev_d      = prev_q;
      ones_d      = ones_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      nbytes_d    = nbytes_q;
      pid_d       = pid_q;
      crc5_d      = crc5_q;
      crc16_d     = crc16_q;
      stuff_err_d = stuff_err_q;
      active_d    = eop_q ? 1'b0 : active_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      eop_d       = 1'b0;
      err_d       = '0;

      if (rx_strb) begin
         if (is_j || is_k) prev_d = rx_dp;
         unique case (state_q)
            S_WAIT_IDLE: begin
               if (is_j) begin
                  if (jcnt_q == JW'(IDLE_J - 1)) begin
                     state_d = S_IDLE;
                     jcnt_d  = '0;
                  end else begin
                     jcnt_d = jcnt_q + 1'b1;
                  end
               end else begin
                  jcnt_d = '0;
               end
            end
            S_IDLE: begin
               if (is_k) begin
                  state_d = S_SYNC;
                  zcnt_d  = ZW'(1);
               end
            end
            S_SYNC: begin
               if (is_se0 || is_se1) begin
                  state_d = S_WAIT_IDLE;
                  jcnt_d  = '0;
               end else if (!dbit) begin
                  if (zcnt_q != ZW'(SYNC_MIN_ZEROS)) zcnt_d = zcnt_q + 1'b1;
               end else if (zcnt_q >= ZW'(SYNC_MIN_ZEROS)) begin
                  state_d     = S_DATA;
                  active_d    = 1'b1;
                  // the SYNC-terminating 1 counts towards the stuffing run
                  ones_d      = 3'd1;
                  shreg_d     = '0;
                  bitcnt_d    = '0;
                  nbytes_d    = '0;
                  pid_d       = '0;
                  crc5_d      = '1;
                  crc16_d     = '1;
                  stuff_err_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DATA: begin
               if (is_se0) begin
                  state_d = S_EOP;
               end else if (is_se1) begin
                  stuff_err_d = 1'b1;
                  state_d     = S_WAIT_EOP;
               end else if (ones_q == 3'd6) begin
                  if (dbit) begin
                     stuff_err_d = 1'b1;
                     state_d     = S_WAIT_EOP;
                  end else begin
                     ones_d = '0;
                  end
               end else begin
                  ones_d   = dbit ? ones_q + 3'd1 : 3'd0;
                  shreg_d  = new_byte[7:1];
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (nbytes_q != 3'd0) begin
                     crc5_d  = {crc5_q[3:0], 1'b0} ^ (crc5_fb ? 5'b00101 : 5'b00000);
                     crc16_d = {crc16_q[14:0], 1'b0} ^ (crc16_fb ? 16'h8005 : 16'h0000);
                  end
                  if (bitcnt_q == 3'd7) begin
                     data_d  = new_byte;
                     valid_d = 1'b1;
                     if (nbytes_q == 3'd0) pid_d = new_byte;
                     if (nbytes_q != 3'd7) nbytes_d = nbytes_q + 3'd1;
                  end
               end
            end
            S_WAIT_EOP: begin
               if (is_se0) state_d = S_EOP;
            end
            S_EOP: begin
               // a full-speed EOP spans two SE0 bit times before the J
               if (is_j) begin
                  eop_d   = 1'b1;
                  err_d   = err_now;
                  state_d = S_IDLE;
               end else if (!is_se0) begin
                  eop_d   = 1'b1;
                  err_d   = err_now | 4'b1000;
                  state_d = S_WAIT_IDLE;
                  jcnt_d  = '0;
               end
            end
            default: state_d = S_WAIT_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_WAIT_IDLE;
         jcnt_q      <= '0;
         zcnt_q      <= '0;
         prev_q      <= 1'b1;
         ones_q      <= '0;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         nbytes_q    <= '0;
         pid_q       <= '0;
         crc5_q      <= '0;
         crc16_q     <= '0;
         stuff_err_q <= 1'b0;
         active_q    <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         eop_q       <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         jcnt_q      <= jcnt_d;
         zcnt_q      <= zcnt_d;
         prev_q      <= prev_d;
         ones_q      <= ones_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         nbytes_q    <= nbytes_d;
         pid_q       <= pid_d;
         crc5_q      <= crc5_d;
         crc16_q     <= crc16_d;
         stuff_err_q <= stuff_err_d;
         active_q    <= active_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         eop_q       <= eop_d;
         err_q       <= err_d;
      end
   end

   assign rx_active = active_q;
   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign rx_eop    = eop_q;
   assign rx_err    = err_q;

endmodule

// File: tb/tb_usb_devrx.sv
// tb_usb_devrx: directed, table-driven bench for usb_devrx.
// Packets are built by a small USB transmit model (SYNC, bit stuffing,
// NRZI) and the received bytes / EOP flags are compared to the table.
module tb_usb_devrx;

   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_SE1 = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_strb;
   logic       rx_dp;
   logic       rx_dn;
   logic       rx_active;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_eop;
   logic [3:0] rx_err;

   always #5 clk = ~clk;

   usb_devrx #(.SYNC_MIN_ZEROS(5), .IDLE_J(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_strb   (rx_strb),
      .rx_dp     (rx_dp),
      .rx_dn     (rx_dn),
      .rx_active (rx_active),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_eop    (rx_eop),
      .rx_err    (rx_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge
   logic [7:0] got_q[$];
   int         neop_tot = 0, act_tot = 0, stuck_tot = 0, errout_tot = 0;
   logic [3:0] last_err = '0;
   logic       last_eop_act = 1'b0;
   logic       prev_eop = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_eop <= 1'b0;
      end else begin
         if (rx_valid) got_q.push_back(rx_data);
         if (rx_eop) begin
            neop_tot     <= neop_tot + 1;
            last_err     <= rx_err;
            last_eop_act <= rx_active;
         end
         if (rx_active) act_tot <= act_tot + 1;
         if (!rx_eop && rx_err != 4'h0) errout_tot <= errout_tot + 1;
         if (prev_eop && rx_active) stuck_tot <= stuck_tot + 1;
         prev_eop <= rx_eop;
      end
   end

   // Transmit model
   logic [1:0] lq[$];
   logic       enc_lvl;
   int         enc_ones;
   bit         enc_flip;

   function automatic logic [1:0] lvl2ls(input logic l);
      return l ? LS_J : LS_K;
   endfunction

   task automatic enc_bit(input logic b);
      if (!b) enc_lvl = ~enc_lvl;
      lq.push_back(lvl2ls(enc_lvl));
      if (b) begin
         enc_ones++;
         if (enc_ones == 6) begin
            if (!enc_flip) enc_lvl = ~enc_lvl;
            enc_flip = 1'b0;
            lq.push_back(lvl2ls(enc_lvl));
            enc_ones = 0;
         end
      end else begin
         enc_ones = 0;
      end
   endtask

   task automatic build_pkt(input logic [47:0] bytes, input int n, input int szeros,
                            input bit flip, input int nextra, input logic [7:0] xbits);
      lq.delete();
      repeat (8) lq.push_back(LS_J);
      enc_lvl = 1'b1;
      for (int i = 0; i < szeros; i++) begin
         enc_lvl = ~enc_lvl;
         lq.push_back(lvl2ls(enc_lvl));
      end
      lq.push_back(lvl2ls(enc_lvl));
      enc_ones = 1;
      enc_flip = flip;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 8; j++) enc_bit(bytes[8*i+j]);
      for (int j = 0; j < nextra; j++) enc_bit(xbits[j]);
      lq.push_back(LS_SE0);
      lq.push_back(LS_SE0);
      lq.push_back(LS_J);
   endtask

   task automatic tx(input logic [1:0] ls, input int gap);
      rx_dp   = ls[1];
      rx_dn   = ls[0];
      rx_strb = 1'b1;
      @(negedge clk);
      rx_strb = 1'b0;
      for (int k = 1; k < gap; k++) @(negedge clk);
   endtask

   task automatic run_pkt(input string nm, input int gap, input int exp_nv,
                          input logic [47:0] exp_bytes, input int exp_neop,
                          input logic [3:0] exp_err, input logic [3:0] mask);
      int bv, be, ba, bs, bo;
      bv = got_q.size(); be = neop_tot; ba = act_tot; bs = stuck_tot; bo = errout_tot;
      foreach (lq[i]) tx(lq[i], gap);
      repeat (4) @(negedge clk);
      chk({nm, " nvalid"}, got_q.size() - bv, exp_nv);
      for (int i = 0; i < exp_nv && bv + i < got_q.size(); i++)
         chk($sformatf("%s byte%0d", nm, i), got_q[bv+i], exp_bytes[8*i +: 8]);
      chk({nm, " neop"}, neop_tot - be, exp_neop);
      if (exp_neop > 0) begin
         chk({nm, " err"}, last_err & mask, exp_err);
         chk({nm, " active_at_eop"}, last_eop_act, 1);
      end else begin
         chk({nm, " active_cycles"}, act_tot - ba, 0);
      end
      chk({nm, " active_after_eop"}, stuck_tot - bs, 0);
      chk({nm, " err_outside_eop"}, errout_tot - bo, 0);
   endtask

   typedef struct {
      string      name;
      logic [47:0] bytes;
      int         n;
      int         szeros;
      bit         flip;
      int         nextra;
      logic [7:0] xbits;
      int         gap;
      int         exp_nv;
      int         exp_neop;
      logic [3:0] exp_err;
      logic [3:0] mask;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int bv, be;
      vecs[0] = '{"ack",       48'hD2,             1, 7, 1'b0, 0, 8'h00, 4, 1, 1, 4'b0000, 4'hF};
      vecs[1] = '{"setup",     48'h10_00_2D,       3, 7, 1'b0, 0, 8'h00, 4, 3, 1, 4'b0000, 4'hF};
      vecs[2] = '{"setup_crc", 48'h11_00_2D,       3, 7, 1'b0, 0, 8'h00, 4, 3, 1, 4'b0010, 4'hF};
      vecs[3] = '{"data0_zlp", 48'h00_00_C3,       3, 7, 1'b0, 0, 8'h00, 1, 3, 1, 4'b0000, 4'hF};
      vecs[4] = '{"data0_crc", 48'h01_00_C3,       3, 7, 1'b0, 0, 8'h00, 4, 3, 1, 4'b0010, 4'hF};
      vecs[5] = '{"data1_ff",  48'hFF_FF_FF_FF_4B, 5, 7, 1'b0, 0, 8'h00, 3, 5, 1, 4'b0000, 4'hF};
      vecs[6] = '{"stuff1",    48'hFF_FF_FF_FF_4B, 5, 7, 1'b1, 0, 8'h00, 4, 1, 1, 4'b1000, 4'b1000};
      vecs[7] = '{"trunc_sync",48'hD2,             1, 4, 1'b0, 0, 8'h00, 4, 0, 0, 4'b0000, 4'hF};
      vecs[8] = '{"bad_pid",   48'hD3,             1, 7, 1'b0, 0, 8'h00, 4, 1, 1, 4'b0011, 4'hF};
      vecs[9] = '{"align",     48'hD2,             1, 7, 1'b0, 3, 8'h02, 4, 1, 1, 4'b0100, 4'hF};

      rst = 1'b1; rx_strb = 1'b0; rx_dp = 1'b1; rx_dn = 1'b0;
      #2;
      chk("reset rx_active", rx_active, 0);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset rx_eop", rx_eop, 0);
      chk("reset rx_data", rx_data, 0);
      chk("reset rx_err", rx_err, 0);
      #20 rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         build_pkt(vecs[v].bytes, vecs[v].n, vecs[v].szeros, vecs[v].flip,
                   vecs[v].nextra, vecs[v].xbits);
         run_pkt(vecs[v].name, vecs[v].gap, vecs[v].exp_nv, vecs[v].bytes,
                 vecs[v].exp_neop, vecs[v].exp_err, vecs[v].mask);
      end

      // K instead of J after the SE0s: bad EOP
      build_pkt(48'hD2, 1, 7, 1'b0, 0, 8'h00);
      lq[lq.size()-1] = LS_K;
      run_pkt("eop_k", 4, 1, 48'hD2, 1, 4'b1000, 4'hF);

      // SE1 inside the packet body
      build_pkt(48'hD2, 1, 7, 1'b0, 0, 8'h00);
      lq.insert(lq.size() - 3, LS_SE1);
      run_pkt("se1", 4, 1, 48'hD2, 1, 4'b1000, 4'hF);

      // Reset right after the second byte of a DATA0 packet
      build_pkt(48'h44_33_22_11_C3, 5, 7, 1'b0, 0, 8'h00);
      bv = got_q.size();
      for (int i = 0; i < 31; i++) tx(lq[i], 4);
      tx(lq[31], 1);
      #3;
      chk("rst pre nvalid", got_q.size() - bv, 2);
      if (got_q.size() >= bv + 2) begin
         chk("rst pre byte0", got_q[bv], 8'hC3);
         chk("rst pre byte1", got_q[bv+1], 8'h11);
      end
      chk("rst pre valid", rx_valid, 1);
      chk("rst pre active", rx_active, 1);
      rst = 1'b1;
      #1;
      chk("rst async valid", rx_valid, 0);
      chk("rst async active", rx_active, 0);
      chk("rst async data", rx_data, 0);
      chk("rst async eop", rx_eop, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      bv = got_q.size(); be = neop_tot;
      for (int i = 32; i < lq.size(); i++) tx(lq[i], 4);
      repeat (4) @(negedge clk);
      chk("rst rest nvalid", got_q.size() - bv, 0);
      chk("rst rest neop", neop_tot - be, 0);
      build_pkt(48'hD2, 1, 7, 1'b0, 0, 8'h00);
      run_pkt("ack_after_rst", 4, 1, 48'hD2, 1, 4'b0000, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
